// File: rtl/spadm_wctl.sv
// Write scheduler and address arbiter in front of the M scratchpad RAM.
// Define SPADM_BYPASS_EN to serve same-address reads from the W bus instead of stalling.
module spadm_wctl (
  input  logic       clk,
  input  logic       reset_l,
  input  logic       stall_h,
  input  logic       rd_en_h,
  input  logic [3:0] rd_spa_h,
  input  logic       wr_req_h,
  input  logic [3:0] wr_spa_h,
  input  logic [1:0] wr_size_h,
  input  logic [1:0] wr_boff_h,
  output logic [3:0] mspa_h,
  output logic [3:0] spw_l,
  output logic       mcs_tmp_l,
  output logic       busy_h,
  output logic       byp_h,
  output logic       pend_h
);

  typedef enum logic {StIdle = 1'b0, StCommit = 1'b1} state_e;

  state_e     state_q, state_d;
  logic [3:0] pend_spa_q, pend_spa_d;
  logic [3:0] pend_be_q, pend_be_d;
  logic [3:0] wr_be;

  // Word masks are truncated at the longword boundary rather than wrapped.
  always_comb begin
    case (wr_size_h)
      2'b00:   wr_be = 4'b0001 << wr_boff_h;
      2'b01:   wr_be = 4'b0011 << wr_boff_h;
      default: wr_be = 4'hF;
    endcase
  end

  always_comb begin
    mspa_h    = rd_spa_h;
    mcs_tmp_l = ~rd_en_h;
    spw_l     = 4'hF;
    busy_h    = 1'b0;
    byp_h     = 1'b0;
    pend_h    = 1'b0;
    if (state_q == StCommit && !stall_h) begin
      mspa_h    = pend_spa_q;
      spw_l     = ~pend_be_q;
      mcs_tmp_l = 1'b1;
      pend_h    = 1'b1;
      if (rd_en_h) begin
`ifdef SPADM_BYPASS_EN
        if (rd_spa_h == pend_spa_q) begin
          byp_h = 1'b1;
        end else begin
          busy_h = 1'b1;
        end
`else
        busy_h = 1'b1;
`endif
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    pend_spa_d = pend_spa_q;
    pend_be_d  = pend_be_q;
    if (!stall_h) begin
      if (busy_h) begin
        // The write commits now; the replayed microword is captured next cycle.
        state_d = StIdle;
      end else begin
        state_d    = wr_req_h ? StCommit : StIdle;
        pend_spa_d = wr_spa_h;
        pend_be_d  = wr_be;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q    <= StIdle;
      pend_spa_q <= 4'h0;
      pend_be_q  <= 4'h0;
    end else begin
      state_q    <= state_d;
      pend_spa_q <= pend_spa_d;
      pend_be_q  <= pend_be_d;
    end
  end

endmodule

// File: tb/tb_spadm_wctl.sv
// Directed bench for spadm_wctl: reset, masks, back-to-back writes, conflicts, bypass, freeze.
module tb_spadm_wctl;

  logic       clk = 1'b0;
  logic       reset_l;
  logic       stall_h;
  logic       rd_en_h;
  logic [3:0] rd_spa_h;
  logic       wr_req_h;
  logic [3:0] wr_spa_h;
  logic [1:0] wr_size_h;
  logic [1:0] wr_boff_h;
  logic [3:0] mspa_h;
  logic [3:0] spw_l;
  logic       mcs_tmp_l;
  logic       busy_h;
  logic       byp_h;
  logic       pend_h;

  int n_checks = 0;
  int n_errors = 0;

  spadm_wctl u_dut (
    .clk       (clk),
    .reset_l   (reset_l),
    .stall_h   (stall_h),
    .rd_en_h   (rd_en_h),
    .rd_spa_h  (rd_spa_h),
    .wr_req_h  (wr_req_h),
    .wr_spa_h  (wr_spa_h),
    .wr_size_h (wr_size_h),
    .wr_boff_h (wr_boff_h),
    .mspa_h    (mspa_h),
    .spw_l     (spw_l),
    .mcs_tmp_l (mcs_tmp_l),
    .busy_h    (busy_h),
    .byp_h     (byp_h),
    .pend_h    (pend_h)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic set_in(input logic rd_en, input logic [3:0] rd_spa, input logic wr_req,
                        input logic [3:0] wr_spa, input logic [1:0] size, input logic [1:0] boff);
    rd_en_h   = rd_en;
    rd_spa_h  = rd_spa;
    wr_req_h  = wr_req;
    wr_spa_h  = wr_spa;
    wr_size_h = size;
    wr_boff_h = boff;
    #1;
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_l = 1'b0;
    stall_h = 1'b0;
    set_in(1'b0, 4'h2, 1'b1, 4'h5, 2'b10, 2'b00);
    check_eq("rst_spw", spw_l, 8'hF);
    check_eq("rst_pend", pend_h, 8'h0);
    check_eq("rst_busy", busy_h, 8'h0);
    check_eq("rst_mspa", mspa_h, 8'h2);
    check_eq("rst_mcs", mcs_tmp_l, 8'h1);
    tick;
    check_eq("rst_edge_spw", spw_l, 8'hF);
    check_eq("rst_edge_pend", pend_h, 8'h0);
    reset_l = 1'b1;
    set_in(1'b0, 4'h2, 1'b0, 4'h0, 2'b00, 2'b00);
    tick;
    check_eq("post_rst_pend", pend_h, 8'h0);
    check_eq("post_rst_spw", spw_l, 8'hF);

    // Long write, boff ignored; idle read in the same cycle has zero latency.
    set_in(1'b1, 4'h9, 1'b1, 4'h5, 2'b10, 2'b01);
    check_eq("idle_rd_mspa", mspa_h, 8'h9);
    check_eq("idle_rd_mcs", mcs_tmp_l, 8'h0);
    check_eq("idle_spw", spw_l, 8'hF);
    tick;
    set_in(1'b0, 4'h0, 1'b0, 4'h0, 2'b00, 2'b00);
    check_eq("long_mspa", mspa_h, 8'h5);
    check_eq("long_spw", spw_l, 8'h0);
    check_eq("long_pend", pend_h, 8'h1);
    check_eq("long_mcs", mcs_tmp_l, 8'h1);
    tick;
    check_eq("long_done_spw", spw_l, 8'hF);
    check_eq("long_done_pend", pend_h, 8'h0);

    // Back-to-back masked writes.
    set_in(1'b0, 4'h0, 1'b1, 4'h1, 2'b00, 2'b10);
    tick;
    set_in(1'b0, 4'h0, 1'b1, 4'h2, 2'b01, 2'b11);
    check_eq("byte2_spw", spw_l, 8'hB);
    check_eq("byte2_mspa", mspa_h, 8'h1);
    tick;
    set_in(1'b0, 4'h0, 1'b1, 4'h3, 2'b01, 2'b00);
    check_eq("word3_spw", spw_l, 8'h7);
    check_eq("word3_mspa", mspa_h, 8'h2);
    tick;
    set_in(1'b0, 4'h0, 1'b0, 4'h0, 2'b00, 2'b00);
    check_eq("word0_spw", spw_l, 8'hC);
    check_eq("word0_mspa", mspa_h, 8'h3);
    tick;
    check_eq("b2b_done_spw", spw_l, 8'hF);

    // Conflicting read; the write in the busy cycle must wait for the replay.
    set_in(1'b0, 4'h0, 1'b1, 4'h3, 2'b10, 2'b00);
    tick;
    set_in(1'b1, 4'hA, 1'b1, 4'h6, 2'b00, 2'b00);
    check_eq("conf_busy", busy_h, 8'h1);
    check_eq("conf_byp", byp_h, 8'h0);
    check_eq("conf_mspa", mspa_h, 8'h3);
    check_eq("conf_spw", spw_l, 8'h0);
    check_eq("conf_mcs", mcs_tmp_l, 8'h1);
    tick;
    check_eq("replay_mspa", mspa_h, 8'hA);
    check_eq("replay_mcs", mcs_tmp_l, 8'h0);
    check_eq("replay_busy", busy_h, 8'h0);
    check_eq("replay_spw", spw_l, 8'hF);
    tick;
    set_in(1'b0, 4'h0, 1'b0, 4'h0, 2'b00, 2'b00);
    check_eq("replay_wr_mspa", mspa_h, 8'h6);
    check_eq("replay_wr_spw", spw_l, 8'hE);
    tick;
    check_eq("replay_wr_done", pend_h, 8'h0);

    // Same-address read during commit.
    set_in(1'b0, 4'h0, 1'b1, 4'h3, 2'b10, 2'b00);
    tick;
    set_in(1'b1, 4'h3, 1'b0, 4'h0, 2'b00, 2'b00);
    check_eq("same_spw", spw_l, 8'h0);
    check_eq("same_pend", pend_h, 8'h1);
`ifdef SPADM_BYPASS_EN
    check_eq("byp_byp", byp_h, 8'h1);
    check_eq("byp_busy", busy_h, 8'h0);
    tick;
    set_in(1'b0, 4'h0, 1'b0, 4'h0, 2'b00, 2'b00);
    check_eq("byp_after_pend", pend_h, 8'h0);
`else
    check_eq("nobyp_busy", busy_h, 8'h1);
    check_eq("nobyp_byp", byp_h, 8'h0);
    tick;
    check_eq("nobyp_replay_mspa", mspa_h, 8'h3);
    check_eq("nobyp_replay_mcs", mcs_tmp_l, 8'h0);
    check_eq("nobyp_replay_busy", busy_h, 8'h0);
    set_in(1'b0, 4'h0, 1'b0, 4'h0, 2'b00, 2'b00);
`endif
    tick;

    // Freeze holds the pending write for three cycles.
    set_in(1'b0, 4'h0, 1'b1, 4'h7, 2'b10, 2'b00);
    tick;
    stall_h = 1'b1;
    set_in(1'b1, 4'hB, 1'b0, 4'h0, 2'b00, 2'b00);
    for (int i = 0; i < 3; i++) begin
      check_eq("frz_spw", spw_l, 8'hF);
      check_eq("frz_mspa", mspa_h, 8'hB);
      check_eq("frz_mcs", mcs_tmp_l, 8'h0);
      check_eq("frz_busy", busy_h, 8'h0);
      check_eq("frz_pend", pend_h, 8'h0);
      tick;
    end
    stall_h = 1'b0;
    set_in(1'b0, 4'h0, 1'b0, 4'h0, 2'b00, 2'b00);
    check_eq("frz_commit_spw", spw_l, 8'h0);
    check_eq("frz_commit_mspa", mspa_h, 8'h7);
    check_eq("frz_commit_pend", pend_h, 8'h1);
    tick;
    check_eq("frz_done_spw", spw_l, 8'hF);

    // Reset during commit discards the write.
    set_in(1'b0, 4'h0, 1'b1, 4'h4, 2'b10, 2'b00);
    tick;
    set_in(1'b0, 4'h0, 1'b0, 4'h0, 2'b00, 2'b00);
    check_eq("rstc_pre_spw", spw_l, 8'h0);
    reset_l = 1'b0;
    #1;
    check_eq("rstc_spw", spw_l, 8'hF);
    check_eq("rstc_pend", pend_h, 8'h0);
    tick;
    reset_l = 1'b1;
    tick;
    check_eq("rstc_after_spw", spw_l, 8'hF);
    check_eq("rstc_after_pend", pend_h, 8'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
